// File: rtl/stage_mem.sv
// -----------------------------------------------------------------------------
// stage_mem
//   Memory-access stage sitting between the EX/MEM and MEM/WB latches.
//   Loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) are carried out one byte at a
//   time over a shared 8-bit RAM port that is arbitrated by mem_req_o /
//   mem_gnt_i. While a transfer is in flight the stage asks the pipeline to
//   stall. Non-memory results pass straight through to write-back.
//
// Ports
//   clk, rst        clock; synchronous active-low reset
//   stall_i         MEM/WB latch held by another source (holds DONE)
//   wd_i, wreg_i    destination register / write enable from EX/MEM
//   wdata_i         ALU result, or store data for stores
//   aluop_i         operation code (selects access size and extension)
//   alusel_i        result class (load / store / other)
//   ma_addr_i       effective byte address
//   wd_o, wreg_o    destination register / write enable to MEM/WB
//   wdata_o         write-back data
//   stall_req_o     stall request to pipeline control
//   mem_req_o       RAM port request to the arbiter
//   mem_gnt_i       RAM port granted this cycle
//   mem_a_o         RAM byte address
//   mem_dout_o      RAM write byte
//   mem_wr_o        RAM write strobe (1 = write, 0 = read)
//   mem_din_i       RAM read byte, valid the cycle after a granted read
// -----------------------------------------------------------------------------
module stage_mem #(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 8,
    parameter int SEL_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic [OP_W-1:0]       aluop_i,
    input  logic [SEL_W-1:0]      alusel_i,
    input  logic [ADDR_W-1:0]     ma_addr_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic                  stall_req_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_W-1:0]     mem_a_o,
    output logic [7:0]            mem_dout_o,
    output logic                  mem_wr_o,
    input  logic [7:0]            mem_din_i
);

    localparam logic [OP_W-1:0] EXE_LB_OP  = OP_W'(8'b1110_0000);
    localparam logic [OP_W-1:0] EXE_LH_OP  = OP_W'(8'b1110_0001);
    localparam logic [OP_W-1:0] EXE_LW_OP  = OP_W'(8'b1110_0011);
    localparam logic [OP_W-1:0] EXE_LBU_OP = OP_W'(8'b1110_0100);
    localparam logic [OP_W-1:0] EXE_LHU_OP = OP_W'(8'b1110_0101);
    localparam logic [OP_W-1:0] EXE_SB_OP  = OP_W'(8'b1110_1000);
    localparam logic [OP_W-1:0] EXE_SH_OP  = OP_W'(8'b1110_1001);
    localparam logic [OP_W-1:0] EXE_SW_OP  = OP_W'(8'b1110_1011);

    localparam logic [SEL_W-1:0] EXE_RES_LOAD  = SEL_W'(3'b110);
    localparam logic [SEL_W-1:0] EXE_RES_STORE = SEL_W'(3'b111);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q;       // index of the byte being transferred
    logic                  rd_pend_q;   // a granted read's byte arrives this cycle
    logic [1:0]            rd_idx_q;    // which byte lane that read belongs to

    logic [1:0]            last_q;      // index of final byte (N-1)
    logic                  is_load_q;
    logic                  sext_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [31:0]           data_q;
    logic [REG_ADDR_W-1:0] wd_q;
    logic                  wreg_q;
    logic [31:0]           rd_buf_q;

    logic                  mem_op;
    logic [1:0]            last_d;
    logic                  sext_d;
    logic [31:0]           load_data;

    assign mem_op = (alusel_i == EXE_RES_LOAD) || (alusel_i == EXE_RES_STORE);

    // Access size and extension from the opcode; unknown opcodes fall back
    // to a full word with no extension.
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        last_d = 2'd3;
        sext_d = 1'b0;
        case (aluop_i)
            EXE_LB_OP:             begin last_d = 2'd0; sext_d = 1'b1; end
            EXE_LBU_OP, EXE_SB_OP: last_d = 2'd0;
            EXE_LH_OP:             begin last_d = 2'd1; sext_d = 1'b1; end
            EXE_LHU_OP, EXE_SH_OP: last_d = 2'd1;
            EXE_LW_OP, EXE_SW_OP:  last_d = 2'd3;
            default:               ;
        endcase
    end

    // Little-endian assembly of the captured bytes, then size extension.
    always_comb begin
        case (last_q)
            2'd0:    load_data = {{24{sext_q & rd_buf_q[7]}},  rd_buf_q[7:0]};
            2'd1:    load_data = {{16{sext_q & rd_buf_q[15]}}, rd_buf_q[15:0]};
            default: load_data = rd_buf_q;
        endcase
    end

    // Next state and outputs. Outputs are forced to zero while rst is low so
    // a transfer cut short by reset issues no further RAM strobes.
    always_comb begin
        state_d     = state_q;
        wd_o        = '0;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        stall_req_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_a_o     = '0;
        mem_dout_o  = '0;
        mem_wr_o    = 1'b0;

        case (state_q)
            S_IDLE:   if (mem_op) state_d = S_ACCESS;
            S_ACCESS: if (mem_gnt_i && (cnt_q == last_q))
                          state_d = is_load_q ? S_WAIT : S_DONE;
            S_WAIT:   state_d = S_DONE;
            S_DONE:   if (!stall_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    if (mem_op) begin
                        stall_req_o = 1'b1;
                    end else begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end
                end
                S_ACCESS: begin
                    stall_req_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_a_o     = addr_q + ADDR_W'(cnt_q);
                    if (!is_load_q) begin
                        mem_wr_o   = 1'b1;
                        mem_dout_o = data_q[{cnt_q, 3'b000} +: 8];
                    end
                end
                S_WAIT: stall_req_o = 1'b1;
                S_DONE: begin
                    wd_o = wd_q;
                    if (is_load_q) begin
                        wreg_o  = wreg_q;
                        wdata_o = load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state.
    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= (state_q == S_ACCESS) && is_load_q && mem_gnt_i;
            rd_idx_q  <= cnt_q;
            if (state_q == S_IDLE)
                cnt_q <= '0;
            else if ((state_q == S_ACCESS) && mem_gnt_i)
                cnt_q <= cnt_q + 2'd1;
        end
    end

    // Transaction datapath.
    // NOTE: these registers have no reset; they are always loaded in IDLE
    // before any state that reads them, so reset would only cost wiring.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && mem_op) begin
            addr_q    <= ma_addr_i;
            data_q    <= wdata_i;
            wd_q      <= wd_i;
            wreg_q    <= wreg_i;
            last_q    <= last_d;
            sext_q    <= sext_d;
            is_load_q <= (alusel_i == EXE_RES_LOAD);
            rd_buf_q  <= '0;
        end else if (rd_pend_q) begin
            rd_buf_q[{rd_idx_q, 3'b000} +: 8] <= mem_din_i;
        end
    end

endmodule
